// File: rtl/tanh_interp_sequencer_if.sv
// tanh_interp_sequencer_if
//   Operand / result handshake bundle for the tanh interpolation sequencer.
//   Signals:
//     in_valid, in_x, in_ready     operand channel (in_x is signed Q4.4)
//     out_valid, out_y, out_ready  result channel (out_y is signed Q4.4)
//   Modports:
//     master  requester / consumer side (drives operands, accepts results)
//     slave   sequencer side
interface tanh_interp_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/tanh_interp_sequencer.sv
// tanh_interp_sequencer
//   Sequences one piecewise-linear tanh evaluation per request. The operand is
//   split into a LUT index (integer part) and a remainder (fraction). The two
//   bracketing samples are read from a synchronous ROM and handed to an
//   external combinational interpolator. Its result is registered and then
//   returned over a valid/ready handshake.
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     bus (slave)       in_valid/in_ready/in_x, out_valid/out_ready/out_y
//     lut_en, lut_addr  ROM read request (data returns the following cycle)
//     lut_data          ROM read data
//     interp_base/next/remaining  interpolator operands (held in registers)
//     interp_value      interpolator result (combinational)
//     busy              high whenever the sequencer is not idle
//   Build option:
//     TANH_ZERO_FRAC_BYPASS_EN  when the fraction is zero, skip the second
//                               read and return the base sample directly.
module tanh_interp_sequencer #(
    parameter int DATA_W     = 8,
    parameter int FRAC_W     = 4,
    parameter int ADDR_W     = 5,
    parameter int LUT_OFFSET = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tanh_interp_sequencer_if.slave bus,
    output logic                 lut_en,
    output logic [ADDR_W-1:0]    lut_addr,
    input  logic [DATA_W-1:0]    lut_data,
    output logic [DATA_W-1:0]    interp_base,
    output logic [DATA_W-1:0]    interp_next,
    output logic [DATA_W-1:0]    interp_remaining,
    input  logic [DATA_W-1:0]    interp_value,
    output logic                 busy
);

`ifdef TANH_ZERO_FRAC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, RD_BASE, RD_NEXT, WAIT_NEXT, INTERP, OUT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_addr_q;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   base_addr_d;
    logic [ADDR_W-1:0]   lut_addr_q;
    logic [FRAC_W-1:0]   rem_q;
    logic [DATA_W-1:0]   base_q;
    logic [DATA_W-1:0]   next_q;
    logic [DATA_W-1:0]   out_y_q;
    logic                zero_frac;

    // Signed integer part plus offset; the offset keeps the result in 0..15,
    // so the +1 neighbour never exceeds the last table entry.
    assign base_addr_d = ADDR_W'($signed(bus.in_x[DATA_W-1:FRAC_W]) + LUT_OFFSET);
    assign next_addr   = base_addr_q + ADDR_W'(1);
    assign zero_frac   = BYPASS && (rem_q == '0);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_y     = out_y_q;
    assign busy          = (state_q != IDLE);

    assign interp_base      = base_q;
    assign interp_next      = next_q;
    assign interp_remaining = {{(DATA_W-FRAC_W){1'b0}}, rem_q};

    always_comb begin
        state_d  = state_q;
        lut_en   = 1'b0;
        lut_addr = lut_addr_q;  // address holds between reads
        case (state_q)
            IDLE:      if (bus.in_valid) state_d = RD_BASE;
            RD_BASE: begin
                lut_en   = 1'b1;
                lut_addr = base_addr_q;
                state_d  = RD_NEXT;
            end
            RD_NEXT: begin
                if (zero_frac) begin
                    state_d = OUT;
                end else begin
                    lut_en   = 1'b1;
                    lut_addr = next_addr;
                    state_d  = WAIT_NEXT;
                end
            end
            WAIT_NEXT: state_d = INTERP;
            INTERP:    state_d = OUT;
            OUT:       if (bus.out_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_addr_q <= '0;
            lut_addr_q  <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            next_q      <= '0;
            out_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            lut_addr_q <= lut_addr;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    base_addr_q <= base_addr_d;
                    rem_q       <= bus.in_x[FRAC_W-1:0];
                end
                RD_NEXT: begin
                    base_q <= lut_data;
                    if (zero_frac) out_y_q <= lut_data;
                end
                WAIT_NEXT: next_q  <= lut_data;
                INTERP:    out_y_q <= interp_value;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_interp_sequencer.sv
// Bench for tanh_interp_sequencer: ROM + interpolator models, a scoreboard
// compare process on the result channel, and directed requests.
module tb_tanh_interp_sequencer;

`ifdef TANH_ZERO_FRAC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lut_en;
    logic [4:0] lut_addr;
    logic [7:0] lut_data;
    logic [7:0] interp_base, interp_next, interp_remaining, interp_value;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int rom [17];
    int exp_q [$];
    int rd_q [$];

    always #5 clk = ~clk;

    tanh_interp_sequencer_if #(.DATA_W(8)) bus ();

    tanh_interp_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus.slave),
        .lut_en           (lut_en),
        .lut_addr         (lut_addr),
        .lut_data         (lut_data),
        .interp_base      (interp_base),
        .interp_next      (interp_next),
        .interp_remaining (interp_remaining),
        .interp_value     (interp_value),
        .busy             (busy)
    );

    initial begin
        for (int i = 0; i < 17; i++) rom[i] = (i <= 5) ? -16 : (i >= 11) ? 16 : 0;
        rom[6] = -15; rom[7] = -12; rom[8] = 0; rom[9] = 12; rom[10] = 15;
    end

    // synchronous ROM
    always @(posedge clk)
        if (lut_en) lut_data <= (lut_addr <= 5'd16) ? 8'(rom[lut_addr]) : 8'h00;

    // combinational interpolator
    always_comb begin
        int bs, nx, rm;
        bs = $signed(interp_base);
        nx = $signed(interp_next);
        rm = int'(interp_remaining);
        interp_value = 8'(bs + (((nx - bs) * rm) >>> 4));
    end

    function automatic int model_y(input logic [7:0] x);
        int b, r;
        b = int'($signed(x[7:4])) + 8;
        r = int'(x[3:0]);
        return rom[b] + (((rom[b+1] - rom[b]) * r) >>> 4);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: every cycle a result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_valid: got out_y %0d expected no result", $signed(bus.out_y));
            end else begin
                chk("stream_out_y", $signed(bus.out_y), exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ROM read monitor
    always @(negedge clk)
        if (rst_n && lut_en) rd_q.push_back(int'(lut_addr));

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) chk("wait_in_ready_timeout", 0, 1);
    endtask

    task automatic do_req(input logic [7:0] x, output int y);
        int  lat, b;
        bit  byp;
        wait_idle();
        rd_q.delete();
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        @(posedge clk);
        exp_q.push_back(model_y(x));
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bus.out_valid && lat < 20);
        y   = $signed(bus.out_y);
        b   = int'($signed(x[7:4])) + 8;
        byp = BYP && (x[3:0] == 4'd0);
        chk($sformatf("latency_%02h", x), lat, byp ? 2 : 4);
        chk($sformatf("busy_%02h", x), int'(busy), 1);
        chk($sformatf("in_ready_%02h", x), int'(bus.in_ready), 0);
        chk($sformatf("reads_%02h", x), rd_q.size(), byp ? 1 : 2);
        if (rd_q.size() >= 1) chk($sformatf("addr0_%02h", x), rd_q[0], b);
        if (rd_q.size() >= 2) chk($sformatf("addr1_%02h", x), rd_q[1], b + 1);
        chk($sformatf("interp_rem_%02h", x), int'(interp_remaining), int'(x[3:0]));
        if (!byp) begin
            chk($sformatf("interp_base_%02h", x), $signed(interp_base), rom[b]);
            chk($sformatf("interp_next_%02h", x), $signed(interp_next), rom[b+1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int y;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = 8'h00;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_y", int'(bus.out_y), 0);
        chk("rst_lut_en", int'(lut_en), 0);
        chk("rst_lut_addr", int'(lut_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_interp", int'({interp_base, interp_next, interp_remaining}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // model pinned to hand-computed values
        chk("model_18", model_y(8'h18), 13);
        chk("model_f8", model_y(8'hF8), -6);
        chk("model_7f", model_y(8'h7F), 16);
        chk("model_80", model_y(8'h80), -16);

        do_req(8'h18, y); chk("y_18", y, 13);
        do_req(8'hF8, y); chk("y_f8", y, -6);
        do_req(8'h7F, y); chk("y_7f", y, 16);
        do_req(8'h80, y); chk("y_80", y, -16);
        do_req(8'h08, y); chk("y_08", y, 6);
        do_req(8'h00, y); chk("y_00", y, 0);

        // backpressure
        wait_idle();
        bus.out_ready = 1'b0;
        do_req(8'h18, y); chk("bp_y", y, 13);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_out_y", $signed(bus.out_y), 13);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", int'(bus.out_valid), 0);
        chk("bp_release_in_ready", int'(bus.in_ready), 1);
        chk("bp_release_busy", int'(busy), 0);

        // asynchronous reset while waiting on the second sample
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_x     = 8'h18;
        @(posedge clk);
        exp_q.push_back(model_y(8'h18));
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_lut_en", int'(lut_en), 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_in_ready", int'(bus.in_ready), 1);
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_out_y", int'(bus.out_y), 0);
        chk("arst_lut_en", int'(lut_en), 0);
        chk("arst_lut_addr", int'(lut_addr), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_interp", int'({interp_base, interp_next, interp_remaining}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", int'(bus.out_valid), 0);
        end
        do_req(8'h18, y); chk("post_rst_y_18", y, 13);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
